// File: rtl/character_transmission.sv
// UART-lite transmitter: serialises start bit, DATA_BITS data bits (LSB first) and a stop bit,
// each OVERSAMPLING clocks long, with a one-deep holding register for back-to-back frames.
module character_transmission #(
  parameter int OVERSAMPLING = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_BITS-1:0] char_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(OVERSAMPLING);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLING - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] hold;
  logic                 full;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic                 handshake;
  logic                 bit_end;

  assign handshake = valid_i && ready_o;
  assign bit_end   = (cnt == CNT_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      shift   <= '0;
      hold    <= '0;
      full    <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      tx_o    <= 1'b1;
      ready_o <= 1'b1;
      busy_o  <= 1'b0;
    end else begin
      cnt <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;

      if (handshake && state != IDLE) begin
        hold    <= char_i;
        full    <= 1'b1;
        ready_o <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (handshake) begin
            shift  <= char_i;
            state  <= START;
            tx_o   <= 1'b0;
            busy_o <= 1'b1;
          end else if (full) begin
            // Character accepted on the last stop edge of the previous frame.
            shift   <= hold;
            full    <= 1'b0;
            ready_o <= 1'b1;
            state   <= START;
            tx_o    <= 1'b0;
            busy_o  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            tx_o    <= shift[0];
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == BIT_LAST) begin
              state <= STOP;
              tx_o  <= 1'b1;
            end else begin
              shift   <= {1'b0, shift[DATA_BITS-1:1]};
              tx_o    <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (full) begin
              shift   <= hold;
              full    <= 1'b0;
              ready_o <= 1'b1;
              state   <= START;
              tx_o    <= 1'b0;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_character_transmission.sv
// Directed bench for character_transmission: frame timing, holding register, reset, narrow config,
// and an independent line decoder for streamed and randomly handshaken characters.
module tb_character_transmission;

  logic       clk;
  logic       rst;
  logic [7:0] char_in;
  logic       valid;
  logic       ready;
  logic       tx;
  logic       busy;

  logic [6:0] char7;
  logic       valid7;
  logic       ready7;
  logic       tx7;
  logic       busy7;

  int vec = 0;
  int err = 0;
  int cyc = 0;

  logic [0:399] tr;
  logic [0:399] bz;
  logic [0:399] rd;

  logic       mon_en = 1'b0;
  logic [7:0] mon_b;
  logic       mon_stop;
  int         mon_stop_bad = 0;
  logic [7:0] rx_q[$];
  int         rx_t[$];
  logic [7:0] exp_q[$];
  logic [7:0] list [0:5];

  character_transmission dut (
    .clk_i(clk), .rst_i(rst), .char_i(char_in), .valid_i(valid),
    .ready_o(ready), .tx_o(tx), .busy_o(busy)
  );

  character_transmission #(.OVERSAMPLING(4), .DATA_BITS(7)) dut7 (
    .clk_i(clk), .rst_i(rst), .char_i(char7), .valid_i(valid7),
    .ready_o(ready7), .tx_o(tx7), .busy_o(busy7)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: samples the middle of each bit after seeing a start bit.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (mon_en && tx === 1'b0) begin
        rx_t.push_back(cyc);
        for (int k = 0; k < 8; k++) begin
          repeat (k == 0 ? 24 : 16) @(posedge clk);
          #1;
          mon_b[k] = tx;
        end
        repeat (16) @(posedge clk);
        #1;
        mon_stop = tx;
        if (mon_stop !== 1'b1) mon_stop_bad++;
        repeat (7) @(posedge clk);
        #1;
        rx_q.push_back(mon_b);
      end
    end
  end

  task automatic rec(input int n);
    for (int i = 0; i < n; i++) begin
      tr[i] = tx; bz[i] = busy; rd[i] = ready;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    vec++;
    if (tx !== 1'b1) begin err++; $display("FAIL reset_tx: got %b expected 1", tx); end
    vec++;
    if (ready !== 1'b1) begin err++; $display("FAIL reset_ready: got %b expected 1", ready); end
    vec++;
    if (busy !== 1'b0) begin err++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single;
    logic [7:0] ch = 8'hA5;
    logic exp_b, got, bad;
    char_in = ch; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    rec(161);
    for (int j = 0; j < 10; j++) begin
      exp_b = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : ch[(j + 7) % 8];
      bad = 1'b0; got = exp_b;
      for (int c = 0; c < 16; c++)
        if (!bad && tr[j*16+c] !== exp_b) begin bad = 1'b1; got = tr[j*16+c]; end
      vec++;
      if (bad) begin err++; $display("FAIL single_bit%0d: got %b expected %b", j, got, exp_b); end
    end
    bad = 1'b0;
    for (int i = 0; i < 160; i++) if (bz[i] !== 1'b1) bad = 1'b1;
    vec++;
    if (bad) begin err++; $display("FAIL single_busy_during: got a 0 sample expected 1"); end
    vec++;
    if (bz[160] !== 1'b0) begin err++; $display("FAIL single_busy_end: got %b expected 0", bz[160]); end
    bad = 1'b0;
    for (int i = 0; i < 161; i++) if (rd[i] !== 1'b1) bad = 1'b1;
    vec++;
    if (bad) begin err++; $display("FAIL single_ready: got a 0 sample expected 1"); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ch;
    logic exp_b, got, bad;
    char_in = 8'h00; valid = 1'b1;
    @(posedge clk); #1;
    char_in = 8'hFF;
    for (int i = 0; i < 321; i++) begin
      tr[i] = tx; bz[i] = busy; rd[i] = ready;
      if (i == 1) char_in = 8'h77;
      if (i == 150) valid = 1'b0;
      @(posedge clk); #1;
    end
    for (int f = 0; f < 2; f++) begin
      ch = (f == 0) ? 8'h00 : 8'hFF;
      for (int j = 0; j < 10; j++) begin
        exp_b = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : ch[(j + 7) % 8];
        bad = 1'b0; got = exp_b;
        for (int c = 0; c < 16; c++)
          if (!bad && tr[f*160+j*16+c] !== exp_b) begin bad = 1'b1; got = tr[f*160+j*16+c]; end
        vec++;
        if (bad) begin err++; $display("FAIL b2b_frame%0d_bit%0d: got %b expected %b", f, j, got, exp_b); end
      end
    end
    vec++;
    if (rd[0] !== 1'b1) begin err++; $display("FAIL b2b_ready_first: got %b expected 1", rd[0]); end
    bad = 1'b0;
    for (int i = 1; i < 160; i++) if (rd[i] !== 1'b0) bad = 1'b1;
    vec++;
    if (bad) begin err++; $display("FAIL b2b_ready_low: got a 1 sample expected 0"); end
    vec++;
    if (rd[160] !== 1'b1) begin err++; $display("FAIL b2b_ready_rise: got %b expected 1", rd[160]); end
    bad = 1'b0;
    for (int i = 0; i < 320; i++) if (bz[i] !== 1'b1) bad = 1'b1;
    vec++;
    if (bad) begin err++; $display("FAIL b2b_busy_gap: got a 0 sample expected 1"); end
    vec++;
    if (bz[320] !== 1'b0 || tr[320] !== 1'b1) begin
      err++; $display("FAIL b2b_third_rejected: got busy=%b tx=%b expected busy=0 tx=1", bz[320], tr[320]);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] ch = 8'h3C;
    logic exp_b, got, bad;
    char_in = 8'h12; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    char_in = 8'h99; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (28) begin @(posedge clk); #1; end
    vec++;
    if (tx !== 1'b0 || busy !== 1'b1 || ready !== 1'b0) begin
      err++; $display("FAIL rst_pre: got tx=%b busy=%b ready=%b expected 0 1 0", tx, busy, ready);
    end
    #2 rst = 1'b1;
    #1;
    vec++;
    if (tx !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) begin
      err++; $display("FAIL rst_async: got tx=%b busy=%b ready=%b expected 1 0 1", tx, busy, ready);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    vec++;
    if (bad) begin err++; $display("FAIL rst_held_lost: got activity expected idle line"); end
    char_in = ch; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    rec(161);
    for (int j = 0; j < 10; j++) begin
      exp_b = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : ch[(j + 7) % 8];
      bad = 1'b0; got = exp_b;
      for (int c = 0; c < 16; c++)
        if (!bad && tr[j*16+c] !== exp_b) begin bad = 1'b1; got = tr[j*16+c]; end
      vec++;
      if (bad) begin err++; $display("FAIL rst_frame_bit%0d: got %b expected %b", j, got, exp_b); end
    end
    vec++;
    if (bz[159] !== 1'b1 || bz[160] !== 1'b0) begin
      err++; $display("FAIL rst_frame_len: got busy159=%b busy160=%b expected 1 0", bz[159], bz[160]);
    end
  endtask

  task automatic test_narrow;
    logic [6:0] ch = 7'h55;
    logic exp_b, got, bad;
    char7 = ch; valid7 = 1'b1;
    @(posedge clk); #1;
    valid7 = 1'b0;
    for (int i = 0; i < 37; i++) begin
      tr[i] = tx7; bz[i] = busy7;
      @(posedge clk); #1;
    end
    for (int j = 0; j < 9; j++) begin
      exp_b = (j == 0) ? 1'b0 : (j == 8) ? 1'b1 : ch[(j + 6) % 7];
      bad = 1'b0; got = exp_b;
      for (int c = 0; c < 4; c++)
        if (!bad && tr[j*4+c] !== exp_b) begin bad = 1'b1; got = tr[j*4+c]; end
      vec++;
      if (bad) begin err++; $display("FAIL narrow_bit%0d: got %b expected %b", j, got, exp_b); end
    end
    vec++;
    if (bz[35] !== 1'b1 || bz[36] !== 1'b0) begin
      err++; $display("FAIL narrow_len: got busy35=%b busy36=%b expected 1 0", bz[35], bz[36]);
    end
  endtask

  task automatic test_stream;
    int idx = 0;
    int quiet = 0;
    logic hs, bad;
    list[0] = 8'h00; list[1] = 8'hFF; list[2] = 8'h5A;
    list[3] = 8'h81; list[4] = 8'h3C; list[5] = 8'hC3;
    rx_q.delete(); rx_t.delete(); exp_q.delete(); mon_stop_bad = 0;
    mon_en = 1'b1;
    for (int c = 0; c < 2000 && !(idx == 6 && quiet >= 3); c++) begin
      valid = (idx < 6);
      char_in = list[idx < 6 ? idx : 0];
      hs = valid && ready;
      @(posedge clk); #1;
      if (hs) begin exp_q.push_back(char_in); idx++; end
      quiet = (busy || idx < 6) ? 0 : quiet + 1;
    end
    valid = 1'b0;
    vec++;
    if (idx != 6 || quiet < 3) begin err++; $display("FAIL stream_timeout: got %0d accepted expected 6", idx); end
    vec++;
    if (rx_q.size() != 6) begin err++; $display("FAIL stream_count: got %0d expected 6", rx_q.size()); end
    for (int k = 0; k < 6 && k < rx_q.size(); k++) begin
      vec++;
      if (rx_q[k] !== list[k]) begin err++; $display("FAIL stream_char%0d: got %h expected %h", k, rx_q[k], list[k]); end
    end
    bad = 1'b0;
    for (int k = 1; k < rx_t.size(); k++) if (rx_t[k] - rx_t[k-1] != 160) bad = 1'b1;
    vec++;
    if (bad) begin err++; $display("FAIL stream_spacing: got a frame gap other than 160 expected 160"); end
    vec++;
    if (mon_stop_bad != 0) begin err++; $display("FAIL stream_stop: got %0d bad stop bits expected 0", mon_stop_bad); end
  endtask

  task automatic test_random;
    int idx = 0;
    int quiet = 0;
    logic hs;
    rx_q.delete(); rx_t.delete(); exp_q.delete(); mon_stop_bad = 0;
    mon_en = 1'b1;
    for (int c = 0; c < 6000 && !(idx == 8 && quiet >= 3); c++) begin
      valid = (idx < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      char_in = 8'($urandom_range(0, 255));
      hs = valid && ready;
      @(posedge clk); #1;
      if (hs) begin exp_q.push_back(char_in); idx++; end
      quiet = (busy || idx < 8) ? 0 : quiet + 1;
    end
    valid = 1'b0;
    mon_en = 1'b0;
    vec++;
    if (idx != 8 || quiet < 3) begin err++; $display("FAIL random_timeout: got %0d accepted expected 8", idx); end
    vec++;
    if (rx_q.size() != exp_q.size()) begin
      err++; $display("FAIL random_count: got %0d frames expected %0d", rx_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++) begin
      vec++;
      if (rx_q[k] !== exp_q[k]) begin err++; $display("FAIL random_char%0d: got %h expected %h", k, rx_q[k], exp_q[k]); end
    end
    vec++;
    if (mon_stop_bad != 0) begin err++; $display("FAIL random_stop: got %0d bad stop bits expected 0", mon_stop_bad); end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; char_in = '0; valid7 = 1'b0; char7 = '0;
    #2;
    test_reset;
    #21 rst = 1'b0;
    @(posedge clk); #1;
    test_single;
    test_back_to_back;
    test_reset_mid;
    test_narrow;
    test_stream;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
